shift_sequencer: RTL

Multi-cycle shift controller that sits in front of the N-bit ALU shift path. Two requesters share it under round-robin arbitration. Each accepted request supplies an operand, a 3-bit shift mode and a shift count. The block applies the selected single-bit shift step once per clock, count times, and returns the result and the last bit shifted out over a valid/ready result port.

---
 rtl/shift_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: round-robin arbitration between two requesters,
// one single-bit shift step per clock, result returned over a valid/ready port.
module shift_sequencer #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_a,
  input  logic [2:0]    req0_mode,
  input  logic [CW-1:0] req0_cnt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_a,
  input  logic [2:0]    req1_mode,
  input  logic [CW-1:0] req1_cnt,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          res_cout,
  output logic          res_id,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_next;
  logic [N-1:0]  r;
  logic [2:0]    mode;
  logic [CW-1:0] remaining;
  logic          id;
  logic          cout;
  logic          prio;

  logic          grant0, grant1;
  logic          req_fire;
  logic          res_fire;
  logic [N-1:0]  step_r;
  logic          step_cout;
  logic [N-1:0]  load_a;
  logic [2:0]    load_mode;
  logic [CW-1:0] load_cnt;

  // The pointer only matters when both requesters compete.
  assign grant0 = req0_valid && (!req1_valid || !prio);
  assign grant1 = req1_valid && (!req0_valid || prio);

  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign req_fire   = req0_ready || req1_ready;

  assign res_valid = (state == DONE);
  assign res_fire  = res_valid && res_ready;
  assign res_data  = r;
  assign res_cout  = cout;
  assign res_id    = id;
  assign busy      = (state != IDLE);

  assign load_a    = grant0 ? req0_a    : req1_a;
  assign load_mode = grant0 ? req0_mode : req1_mode;
  assign load_cnt  = grant0 ? req0_cnt  : req1_cnt;

  always_comb begin
    step_r    = r;
    step_cout = 1'b0;
    unique case (mode)
      3'b000, 3'b100: begin step_r = {r[N-2:0], 1'b0};   step_cout = r[N-1]; end
      3'b001:         begin step_r = {r[N-2:0], 1'b1};   step_cout = r[N-1]; end
      3'b010:         begin step_r = {1'b0, r[N-1:1]};   step_cout = r[0];   end
      3'b011:         begin step_r = {1'b1, r[N-1:1]};   step_cout = r[0];   end
      3'b101:         begin step_r = {r[N-1], r[N-1:1]}; step_cout = r[0];   end
      3'b110:         begin step_r = {r[N-2:0], r[N-1]}; step_cout = r[N-1]; end
      3'b111:         begin step_r = {r[0], r[N-1:1]};   step_cout = r[0];   end
      default:        begin step_r = r;                  step_cout = 1'b0;   end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_fire) state_next = (load_cnt == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining == CW'(1)) state_next = DONE;
      DONE:    if (res_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      mode      <= '0;
      remaining <= '0;
      id        <= 1'b0;
      cout      <= 1'b0;
      prio      <= 1'b0;
    end else begin
      if (req_fire) begin
        r         <= load_a;
        mode      <= load_mode;
        remaining <= load_cnt;
        id        <= grant1;
        cout      <= 1'b0;
        prio      <= grant0;
      end else if (state == SHIFT) begin
        r         <= step_r;
        cout      <= step_cout;
        remaining <= remaining - CW'(1);
      end
    end
  end

endmodule
